dc_ipu_muladd_seq: RTL

iterative multiply-add, a = q*b + r. It rebuilds the dividend from a divider's quotient/remainder tuple and flags tuples that are not valid division results.

Interface
REQ-001 Parameter Q_WIDTH, default 8, quotient width (>=1).
REQ-002 Parameter B_WIDTH, default 8, divisor/remainder width (>=1).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clr  in  1  synchronous flush of in-flight operation.
REQ-006 in_valid  in  1  input tuple valid.
REQ-007 in_ready  out  1  block can accept tuple (combinational).
REQ-008 q  in  Q_WIDTH  multiplier (quotient).
REQ-009 b  in  B_WIDTH  multiplicand (divisor).
REQ-010 r  in  B_WIDTH  addend (remainder).
REQ-011 out_valid  out  1  result valid (registered).
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 a  out  Q_WIDTH+B_WIDTH  result q*b+r (registered).
REQ-014 rem_err  out  1  registered; 1 when r >= b, including b==0.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready. On accept, q, b and r SHALL be latched, acc SHALL be loaded with zero-extended r, cnt SHALL be set to 0, rem_err SHALL be computed, and the state SHALL go to BUSY.
REQ-017 Each BUSY edge SHALL execute step k = cnt: if q bit k is 1, then acc += b << k. Then cnt++.
REQ-018 On the BUSY edge with cnt == Q_WIDTH-1, the state SHALL go to DONE and the final acc SHALL be loaded into a.
REQ-019 out_valid SHALL be 1 exactly when the state is DONE. The first out_valid cycle SHALL begin Q_WIDTH edges after the accept edge.
REQ-020 a and rem_err SHALL hold stable while out_valid && !out_ready.
REQ-021 in_ready SHALL be !clr && (IDLE || (DONE && out_ready)).
REQ-022 Back-to-back: an edge that is both a DONE handshake and a new accept SHALL go straight to BUSY with the new operands. Sustained throughput SHALL be 1 result per Q_WIDTH+1 cycles.
REQ-023 DONE && out_ready without a new accept SHALL go to IDLE.
REQ-024 Arithmetic SHALL be unsigned and exact. The result cannot overflow, since (2^Q_WIDTH-1)(2^B_WIDTH-1)+(2^B_WIDTH-1) < 2^(Q_WIDTH+B_WIDTH).
REQ-025 rem_err SHALL NOT alter a. The result is computed regardless.
REQ-026 in_valid and operands SHALL be ignored in BUSY, and during DONE without out_ready.
REQ-027 clr SHALL force IDLE on the next edge from any state. The in-flight or unconsumed result SHALL be discarded, and out_valid SHALL be 0 next cycle. The a register SHALL be left unchanged.
REQ-028 Priority SHALL be reset > clr > handshake/FSM.
REQ-029 Q_WIDTH == 1 SHALL give a single BUSY cycle.

Reset
REQ-030 On reset, the state SHALL go to IDLE and cnt, acc, a, rem_err and out_valid SHALL be 0. in_ready SHALL be 1 the cycle after reset deasserts, provided clr == 0.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abort the operation. No out_valid SHALL appear for the aborted tuple.

Verification
REQ-032 Q=B=8, q=13, b=7, r=5, out_ready=1 -> a=96, rem_err=0. out_valid rises 8 cycles after accept and lasts 1 cycle.
REQ-033 q=255, b=255, r=254 -> a=65279, rem_err=0. q=17, b=0, r=0 -> a=0, rem_err=1. q=3, b=4, r=4 -> a=16, rem_err=1.
REQ-034 Backpressure: result q=2, b=3, r=1 held with out_ready=0 for 5 cycles -> a=7 stable, out_valid=1, in_ready=0 throughout. Then out_ready=1 with new in_valid (q=1, b=1, r=0) -> same-edge handshake and accept; next result a=1 after 8 more cycles.
REQ-035 clr pulsed on the 3rd BUSY cycle -> IDLE next edge, in_ready=1, out_valid stays 0. A following tuple q=4, b=5, r=0 -> a=20.
REQ-036 reset asserted in DONE with out_ready=0 -> out_valid=0, a=0, rem_err=0 next cycle. The aborted result is never presented.
REQ-037 Random regression: 10k tuples with random out_ready and clr -> every a equals q*b+r and every rem_err equals (r>=b). No result is lost or duplicated except those flushed by clr/reset.

---
 rtl/dc_ipu_muladd_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/dc_ipu_muladd_seq.sv
// Iterative shift-and-add multiply-add a = q*b + r, one quotient bit per cycle.
// Rebuilds a dividend from a quotient/remainder tuple and flags r >= b.
module dc_ipu_muladd_seq #(
    parameter int Q_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Q_WIDTH-1:0]         q,
    input  logic [B_WIDTH-1:0]         b,
    input  logic [B_WIDTH-1:0]         r,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Q_WIDTH+B_WIDTH-1:0] a,
    output logic                       rem_err
);

    localparam int AW    = Q_WIDTH + B_WIDTH;
    localparam int CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [Q_WIDTH-1:0] qsh_q;
    logic [AW-1:0]      bsh_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [AW-1:0]      a_q;
    logic               rem_err_q;
    logic               out_valid_q;
    logic               accept;
    logic               last_step;

    function automatic logic [AW-1:0] mac_step(input logic [AW-1:0] acc,
                                               input logic [AW-1:0] addend,
                                               input logic          en);
        mac_step = en ? (acc + addend) : acc;
    endfunction

    assign in_ready  = !clr && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == CNT_W'(Q_WIDTH - 1));
    // q is consumed LSB-first while b walks left, so bsh_q always equals b << cnt.
    assign acc_d     = mac_step(acc_q, bsh_q, qsh_q[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            qsh_q       <= '0;
            bsh_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            rem_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            qsh_q       <= q;
            bsh_q       <= AW'(b);
            acc_q       <= AW'(r);
            rem_err_q   <= (r >= b);
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUSY: begin
                    acc_q <= acc_d;
                    qsh_q <= qsh_q >> 1;
                    bsh_q <= bsh_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        a_q         <= acc_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign rem_err   = rem_err_q;

endmodule
